ads1675_multi_rx: RTL and testbench



---
 rtl/ads1675_multi_rx.sv | 221 ++++++++++++++++++++++
 tb/tb_ads1675_multi_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ads1675_multi_rx.sv
// ads1675_multi_rx
//   Receives NCH ADS1675 ADCs that share one SCLK and DRDY and have their own
//   DOUT lines. After leaving IDLE it drops DISCARD_FRAMES frames, checks the
//   DRDY period on every frame, and emits each frame as one packed word on a
//   valid/ready stream.
//
//   Ports:
//     clk, rst            ADC SCLK (the only clock), synchronous active-high reset
//     en                  capture enable; also drives start
//     drdy, dout[NCH]     shared DRDY and per-channel serial data
//     m_data/m_valid/m_ready  packed word out, channel i at [i*DW +: DW]
//     frame_err, overflow one-cycle status pulses
//     err_sticky          OR of all status pulses since rst
//     dr, start, cs_n, pown, fpath, ll_cfg  static device straps
//
//   Build option ADS1675_STATUS_CNT_EN adds saturating err_cnt/ovf_cnt outputs.
`timescale 1ns/1ps
module ads1675_multi_rx #(
  parameter int          NCH            = 4,
  parameter int          DW             = 24,
  parameter int          FRAME_LEN      = 48,
  parameter int          MSB_OFFSET     = 0,
  parameter int          DISCARD_FRAMES = 2,
  parameter logic [2:0]  DR_CODE        = 3'b100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              drdy,
  input  logic [NCH-1:0]    dout,
  output logic [NCH*DW-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_err,
  output logic              overflow,
  output logic              err_sticky,
  output logic [2:0]        dr,
  output logic              start,
  output logic              cs_n,
  output logic              pown,
  output logic              fpath,
  output logic              ll_cfg
`ifdef ADS1675_STATUS_CNT_EN
  ,
  output logic [15:0]       err_cnt,
  output logic [15:0]       ovf_cnt
`endif
);

  localparam logic [7:0] FL_M1  = 8'(FRAME_LEN - 1);
  localparam logic [7:0] TMO    = 8'(2 * FRAME_LEN);
  localparam logic [7:0] DONE   = 8'(MSB_OFFSET + DW);
  localparam logic [7:0] OFF    = 8'(MSB_OFFSET);
  localparam logic [7:0] DW8    = 8'(DW);
  localparam logic [7:0] DISC_N = 8'(DISCARD_FRAMES);

  typedef enum logic [1:0] {IDLE, SYNC, DISCARD, RUN} state_t;
  state_t state_q, state_d;

  logic              drdy_r_q, drdy_rr_q;
  logic [NCH-1:0]    dout_r_q;
  logic [7:0]        period_cnt_q, period_cnt_d;
  logic [7:0]        disc_cnt_q, disc_cnt_d;
  logic [7:0]        bit_cnt_q, bit_cnt_d;
  logic              frame_ok_q, frame_ok_d;
  logic [NCH*DW-1:0] sh_q, sh_d;
  logic [NCH*DW-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q, overflow_d;
  logic              err_sticky_q, err_sticky_d;

  logic       fsync, checking, match, timeout, disc_last, emit, shift_en;
  logic [7:0] cyc;

  // Input pipeline is left out of reset so a DRDY already high when rst
  // releases is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    drdy_r_q  <= drdy;
    drdy_rr_q <= drdy_r_q;
    dout_r_q  <= dout;
  end

  always_comb begin
    fsync     = drdy_r_q & ~drdy_rr_q;
    checking  = en && (state_q == DISCARD || state_q == RUN);
    match     = (period_cnt_q == FL_M1);
    timeout   = checking && !fsync && (period_cnt_q == TMO);
    disc_last = ((disc_cnt_q + 8'd1) == DISC_N);
    // bit position within the frame, 0 on the fsync cycle itself
    cyc       = fsync ? '0 : bit_cnt_q;
    // wraps to a large value before MSB_OFFSET, so one compare covers the window
    shift_en  = ((cyc - OFF) < DW8);
    emit      = en && (state_q == RUN) && frame_ok_q && (cyc == DONE);
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = SYNC;
        SYNC:    if (fsync) state_d = (DISCARD_FRAMES == 0) ? RUN : DISCARD;
        DISCARD: if (timeout) state_d = SYNC;
                 else if (fsync && match && disc_last) state_d = RUN;
        RUN:     if (timeout) state_d = SYNC;
        default: state_d = IDLE;
      endcase
    end
  end

  // datapath and outputs
  always_comb begin
    period_cnt_d = '0;
    if (checking && !fsync)
      period_cnt_d = (period_cnt_q == 8'hFF) ? period_cnt_q : period_cnt_q + 8'd1;

    frame_err_d = checking && ((fsync && !match) || timeout);

    disc_cnt_d = disc_cnt_q;
    if (!en || state_q == IDLE)             disc_cnt_d = '0;
    else if (fsync && state_q == SYNC)      disc_cnt_d = '0;
    else if (fsync && state_q == DISCARD)   disc_cnt_d = match ? disc_cnt_q + 8'd1 : '0;

    // A frame is eligible for output only if it opened in RUN (or on the
    // edge entering RUN) with a correct period; any later fsync re-decides.
    if (fsync)
      frame_ok_d = en && ((state_q == SYNC && DISCARD_FRAMES == 0) ||
                          (state_q == DISCARD && match && disc_last) ||
                          (state_q == RUN && match));
    else
      frame_ok_d = frame_ok_q && (state_d == RUN);

    bit_cnt_d = (cyc > DONE) ? cyc : cyc + 8'd1;

    sh_d = sh_q;
    if (shift_en)
      for (int unsigned i = 0; i < NCH; i++)
        sh_d[i*DW +: DW] = {sh_q[i*DW +: DW-1], dout_r_q[i]};

    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    overflow_d = 1'b0;
    if (emit) begin
      m_data_d   = sh_q;
      m_valid_d  = 1'b1;
      overflow_d = m_valid_q && !m_ready;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    err_sticky_d = err_sticky_q | frame_err_d | overflow_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      disc_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      frame_ok_q   <= 1'b0;
      sh_q         <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      disc_cnt_q   <= disc_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_ok_q   <= frame_ok_d;
      sh_q         <= sh_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
      err_sticky_q <= err_sticky_d;
    end
  end

`ifdef ADS1675_STATUS_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (frame_err_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    if (overflow_d  && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign ovf_cnt = ovf_cnt_q;
`endif

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign err_sticky = err_sticky_q;
  assign dr         = DR_CODE;
  assign start      = en;
  assign cs_n       = 1'b0;
  assign pown       = 1'b1;
  assign fpath      = 1'b0;
  assign ll_cfg     = 1'b1;

endmodule

// File: tb/tb_ads1675_multi_rx.sv
`timescale 1ns/1ps
module tb_ads1675_multi_rx;

  localparam int NCH = 4;
  localparam int DW  = 24;
  localparam int W   = NCH * DW;
  localparam int LAT = DW + 2;

  logic          clk = 1'b0;
  logic          rst, en, drdy, m_ready;
  logic [NCH-1:0] dout;
  logic [W-1:0]  m_data;
  logic          m_valid, frame_err, overflow, err_sticky;
  logic [2:0]    dr;
  logic          start, cs_n, pown, fpath, ll_cfg;
`ifdef ADS1675_STATUS_CNT_EN
  logic [15:0]   err_cnt, ovf_cnt;
`endif

  ads1675_multi_rx #(.NCH(NCH), .DW(DW), .FRAME_LEN(48), .MSB_OFFSET(0),
                     .DISCARD_FRAMES(2), .DR_CODE(3'b100)) dut (
    .clk(clk), .rst(rst), .en(en), .drdy(drdy), .dout(dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .frame_err(frame_err), .overflow(overflow), .err_sticky(err_sticky),
    .dr(dr), .start(start), .cs_n(cs_n), .pown(pown), .fpath(fpath), .ll_cfg(ll_cfg)
`ifdef ADS1675_STATUS_CNT_EN
    , .err_cnt(err_cnt), .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  cyc;   // 0: latency not checked
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_total = 0, n_bad = 0;
  int unsigned cyc_cnt = 0, err_cyc = 0, last_rise = 0;
  int unsigned n_errp = 0, n_ovfp = 0;
  string       phase = "reset";

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard / pulse monitor
  always @(negedge clk) begin
    if (frame_err) begin n_errp++; err_cyc = cyc_cnt; end
    if (overflow) n_ovfp++;
    if (m_valid && m_ready) begin
      check({phase, "_word_pending"}, 128'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check({phase, "_data"}, m_data, e.data);
        if (e.cyc != 0) check({phase, "_latency"}, cyc_cnt, e.cyc);
      end
    end
  end

  function automatic logic [W-1:0] base_word();
    logic [W-1:0] w;
    for (int c = 0; c < NCH; c++) w[c*DW +: DW] = DW'(32'h100000 + c);
    return w;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] w;
    for (int c = 0; c < NCH; c++) w[c*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  // One DRDY period: rise at k=0, MSB-first bits for k<DW.
  // mode 1: drop en at k=at for 3 cycles; mode 2: 1-cycle rst at k=at.
  task automatic send_frame(input logic [W-1:0] w, input int period, input bit emit_exp,
                            input int mode, input int at);
    for (int k = 0; k < period; k++) begin
      @(posedge clk); #1;
      drdy = (k < period / 2);
      for (int c = 0; c < NCH; c++)
        dout[c] = (k < DW) ? w[c*DW + DW - 1 - k] : 1'($urandom);
      if (k == 0) begin
        last_rise = cyc_cnt;
        if (emit_exp) begin
          exp_t e;
          e.data = w;
          e.cyc  = cyc_cnt + LAT;
          exp_q.push_back(e);
        end
      end
      if (mode == 1 && k == at)     en = 1'b0;
      if (mode == 1 && k == at + 3) en = 1'b1;
      if (mode == 2 && k == at)     rst = 1'b1;
      if (mode == 2 && k == at + 1) begin
        rst = 1'b0;
        check("rst_m_valid",    m_valid,    0);
        check("rst_m_data",     m_data,     0);
        check("rst_frame_err",  frame_err,  0);
        check("rst_overflow",   overflow,   0);
        check("rst_err_sticky", err_sticky, 0);
`ifdef ADS1675_STATUS_CNT_EN
        check("rst_err_cnt",    err_cnt,    0);
        check("rst_ovf_cnt",    ovf_cnt,    0);
`endif
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; drdy = 1'b0; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w, x1, x2, x3;
    int unsigned  e0, o0, rt;

    rst = 1'b1; en = 1'b0; drdy = 1'b0; dout = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_m_valid",    m_valid,    0);
    check("reset_m_data",     m_data,     0);
    check("reset_frame_err",  frame_err,  0);
    check("reset_overflow",   overflow,   0);
    check("reset_err_sticky", err_sticky, 0);
    check("strap_dr",         dr,         3'b100);
    check("strap_start_off",  start,      0);
    check("strap_cs_n",       cs_n,       0);
    check("strap_pown",       pown,       1);
    check("strap_fpath",      fpath,      0);
    check("strap_ll_cfg",     ll_cfg,     1);
    rst = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    #1 check("strap_start_on", start, 1);

    // frames 0,1 dropped, 2..5 emitted
    phase = "basic";
    for (int f = 0; f < 6; f++) send_frame(base_word(), 48, f >= 2, 0, 0);
    check("basic_drain", exp_q.size(), 0);
    check("basic_no_err", n_errp, 0);

    phase = "neg";
    w = base_word(); w[DW-1:0] = 24'h800000;
    send_frame(w, 48, 1, 0, 0);
    w[DW-1:0] = 24'hFFFFFF;
    send_frame(w, 48, 1, 0, 0);
    check("neg_drain", exp_q.size(), 0);

    // 40-clk period: the frame opened by the early DRDY is dropped
    phase = "short";
    e0 = n_errp;
    send_frame(rnd_word(), 40, 1, 0, 0);
    send_frame(rnd_word(), 48, 0, 0, 0);
    send_frame(rnd_word(), 48, 1, 0, 0);
    check("short_err_pulses", n_errp - e0, 1);
    check("short_err_sticky", err_sticky, 1);
    check("short_drain", exp_q.size(), 0);

    phase = "bp";
    o0 = n_ovfp;
    x1 = rnd_word(); x2 = rnd_word(); x3 = rnd_word();
    m_ready = 1'b0;
    send_frame(x1, 48, 0, 0, 0);
    check("bp_valid_held", m_valid, 1);
    check("bp_hold_x1", m_data, x1);
    send_frame(x2, 48, 0, 0, 0);
    check("bp_hold_x2", m_data, x2);
    send_frame(x3, 48, 0, 0, 0);
    check("bp_hold_x3", m_data, x3);
    check("bp_ovf_pulses", n_ovfp - o0, 2);
`ifdef ADS1675_STATUS_CNT_EN
    check("bp_ovf_cnt", ovf_cnt, 2);
    check("bp_err_cnt", err_cnt, 1);
`endif
    begin
      exp_t e;
      e.data = x3; e.cyc = 0;
      exp_q.push_back(e);
    end
    m_ready = 1'b1;
    send_frame(rnd_word(), 48, 1, 0, 0);
    check("bp_drain", exp_q.size(), 0);

    // DRDY stalls: timeout at period_cnt = 96, then resync and discard again
    phase = "tmo";
    e0 = n_errp;
    send_frame(rnd_word(), 48, 1, 0, 0);
    rt = last_rise;
    idle(60);
    check("tmo_err_pulses", n_errp - e0, 1);
    check("tmo_err_cycle", err_cyc, rt + 99);
    for (int f = 0; f < 4; f++) send_frame(rnd_word(), 48, f >= 2, 0, 0);
    check("tmo_drain", exp_q.size(), 0);

    phase = "endrop";
    send_frame(rnd_word(), 48, 0, 1, 10);
    for (int f = 0; f < 4; f++) send_frame(rnd_word(), 48, f >= 2, 0, 0);
    check("endrop_drain", exp_q.size(), 0);

    phase = "rst";
    m_ready = 1'b0;
    send_frame(rnd_word(), 48, 0, 0, 0);
    check("rst_pre_valid", m_valid, 1);
    send_frame(rnd_word(), 48, 0, 2, 10);
    m_ready = 1'b1;
    for (int f = 0; f < 4; f++) send_frame(rnd_word(), 48, f >= 2, 0, 0);
    check("rst_drain", exp_q.size(), 0);

    idle(4);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
